// File: rtl/instr_prefetch.sv
// Instruction prefetch queue for the 8080 core: fetches 3-byte windows at the PC,
// length-decodes each opcode and queues {pc, bytes, len} for the decoder.
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] fetch_addr,
  input  logic [23:0] fetch_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        iq_valid,
  input  logic        iq_ready,
  output logic [15:0] iq_pc,
  output logic [23:0] iq_instr,
  output logic [1:0]  iq_len,
  output logic        halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    CAPTURE,
    HALT
  } state_t;

  state_t        state, state_next;
  logic [15:0]   pc;
  logic [15:0]   pc_inc;
  logic [7:0]    opcode;
  logic [1:0]    cap_len;
  logic          enq, deq;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [15:0]   q_pc    [DEPTH];
  logic [23:0]   q_instr [DEPTH];
  logic [1:0]    q_len   [DEPTH];

  function automatic logic [1:0] decode_len(input logic [7:0] o);
    logic [1:0] l;
    l = 2'd1;
    if ((o[7:6] == 2'b00 && o[3:0] == 4'b0001) ||
        o == 8'h22 || o == 8'h2A || o == 8'h32 || o == 8'h3A ||
        o == 8'hC3 || o == 8'hCB ||
        (o[7:6] == 2'b11 && o[2:0] == 3'b010) ||
        o == 8'hCD || o == 8'hDD || o == 8'hED || o == 8'hFD ||
        (o[7:6] == 2'b11 && o[2:0] == 3'b100))
      l = 2'd3;
    else if ((o[7:6] == 2'b00 && o[2:0] == 3'b110) ||
             (o[7:6] == 2'b11 && o[2:0] == 3'b110) ||
             o == 8'hD3 || o == 8'hDB)
      l = 2'd2;
    return l;
  endfunction

  assign opcode  = fetch_data[23:16];
  assign cap_len = decode_len(opcode);
  assign pc_inc  = pc + {14'd0, cap_len};
  assign enq     = (state == CAPTURE);
  assign deq     = iq_valid && iq_ready;

  assign iq_valid = (count != '0);
  assign iq_pc    = q_pc[rd_ptr];
  assign iq_instr = q_instr[rd_ptr];
  assign iq_len   = q_len[rd_ptr];
  assign halted   = (state == HALT);

  // CAPTURE drives the next PC straight to memory so the following read overlaps
  always_comb begin
    state_next = state;
    fetch_addr = pc;
    case (state)
      ISSUE:   if (count < FULL_CNT) state_next = WAIT;
      WAIT:    state_next = CAPTURE;
      CAPTURE: begin
        fetch_addr = pc_inc;
        if (opcode == 8'h76)
          state_next = HALT;
        else if (count < LAST_CNT)
          state_next = WAIT;
        else
          state_next = ISSUE;
      end
      HALT:    state_next = HALT;
      default: state_next = ISSUE;
    endcase
    if (redirect_valid)
      state_next = ISSUE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ISSUE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid)
        pc <= redirect_pc;
      else if (state == CAPTURE)
        pc <= pc_inc;
    end
  end

  // Redirect wins over any same-cycle enqueue or dequeue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
        q_len[i]   <= '0;
      end
    end else if (enq && !redirect_valid) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= fetch_data;
      q_len[wr_ptr]   <= cap_len;
    end
  end

endmodule
